// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL), one log2 stage per register, valid/ready with global stall.
// Optional carry/zero flags built only when BSHIFT_FLAGS_EN is defined.
module barrel_shifter_pipe #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic             r_valid [SHW];
    logic [WIDTH-1:0] r_data  [SHW];
    logic [1:0]       r_op    [SHW];
    logic [SHW-1:0]   r_shamt [SHW];

    logic             w_vin  [SHW];
    logic [WIDTH-1:0] w_din  [SHW];
    logic [1:0]       w_op   [SHW];
    logic [SHW-1:0]   w_sh   [SHW];
    logic [WIDTH-1:0] w_sft  [SHW];
    logic [WIDTH-1:0] w_dout [SHW];
    logic             w_stall;

    assign w_stall   = r_valid[SHW-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_data[SHW-1];

    // Stage k shifts by 2^k when its shamt bit k is set
    always_comb begin
        w_vin[0] = in_valid;
        w_din[0] = in_data;
        w_op[0]  = in_op;
        w_sh[0]  = in_shamt;
        for (int k = 1; k < SHW; k++) begin
            w_vin[k] = r_valid[k-1];
            w_din[k] = r_data[k-1];
            w_op[k]  = r_op[k-1];
            w_sh[k]  = r_shamt[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            case (w_op[k])
                OP_SLL:  w_sft[k] = w_din[k] << (1 << k);
                OP_SRL:  w_sft[k] = w_din[k] >> (1 << k);
                OP_SRA:  w_sft[k] = WIDTH'($signed(w_din[k]) >>> (1 << k));
                default: w_sft[k] = (w_din[k] << (1 << k)) | (w_din[k] >> (WIDTH - (1 << k)));
            endcase
            w_dout[k] = w_sh[k][k] ? w_sft[k] : w_din[k];
        end
    end

    // All stages advance together unless the output is back-pressured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_op[k]    <= '0;
                r_shamt[k] <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= w_vin[k];
                r_data[k]  <= w_dout[k];
                r_op[k]    <= w_op[k];
                r_shamt[k] <= w_sh[k];
            end
        end
    end

`ifdef BSHIFT_FLAGS_EN
    logic r_carry [SHW];
    logic w_cin   [SHW];
    logic w_cout  [SHW];
    logic r_zero;

    // Carry is the last bit leaving each shifting stage; non-shifting stages keep it
    always_comb begin
        w_cin[0] = 1'b0;
        for (int k = 1; k < SHW; k++) begin
            w_cin[k] = r_carry[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            if (!w_sh[k][k]) begin
                w_cout[k] = w_cin[k];
            end else if (w_op[k] == OP_SRL || w_op[k] == OP_SRA) begin
                w_cout[k] = w_din[k][(1 << k) - 1];
            end else begin
                w_cout[k] = w_din[k][WIDTH - (1 << k)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                r_carry[k] <= 1'b0;
            end
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < SHW; k++) begin
                r_carry[k] <= w_cout[k];
            end
            r_zero <= (w_dout[SHW-1] == '0);
        end
    end

    assign out_carry = r_carry[SHW-1];
    assign out_zero  = r_zero;
`else
    assign out_carry = 1'b0;
    assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=16): directed vectors, stall, reset, latency.
// Expected flags follow BSHIFT_FLAGS_EN; with it undefined carry/zero are expected to stay 0.
module tb_barrel_shifter_pipe;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    barrel_shifter_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic flg(input logic v);
`ifdef BSHIFT_FLAGS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] op,
                        input logic [15:0] ed, input logic ec);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", w);
        end else begin
            sb.push_back('{d: ed, c: flg(ec), z: flg(ed == 16'h0000)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            w++;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops expected results on every output handshake, checks hold during stall
    initial begin : monitor
        exp_t        e;
        logic        stl;
        logic [15:0] hd;
        logic        hc;
        logic        hz;
        stl = 1'b0;
        hd  = '0;
        hc  = 1'b0;
        hz  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stl = 1'b0;
            end else begin
                if (stl) begin
                    chk("hold_data", 32'(out_data), 32'(hd));
                    chk("hold_carry", 32'(out_carry), 32'(hc));
                    chk("hold_zero", 32'(out_zero), 32'(hz));
                end
                if (out_valid && !out_ready) begin
                    chk("in_ready_stall", 32'(in_ready), 32'd0);
                    stl = 1'b1;
                    hd  = out_data;
                    hc  = out_carry;
                    hz  = out_zero;
                end else begin
                    stl = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got 0x%0h, expected no result", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_carry", 32'(out_carry), 32'(e.c));
                        chk("out_zero", 32'(out_zero), 32'(e.z));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SLL;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_carry", 32'(out_carry), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SLL with exact latency check
        send(16'h8001, 4'd1, SLL, 16'h0002, 1'b1);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge3", 32'(out_valid), 32'd1);
        drain();

        // Right shifts, rotate, shamt 0
        send(16'h8000, 4'd15, SRA, 16'hFFFF, 1'b0);
        send(16'h8000, 4'd15, SRL, 16'h0001, 1'b0);
        send(16'h0001, 4'd1,  SRL, 16'h0000, 1'b1);
        send(16'h1234, 4'd4,  ROL, 16'h2341, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(16'h0000, 4'd0, 2'(i), 16'h0000, 1'b0);
        end
        send(16'h1234, 4'd0, SRA, 16'h1234, 1'b0);
        drain();

        // Back-to-back stream with out_ready low for 5 cycles
        fork
            begin
                send(16'h00F0, 4'd4,  SLL, 16'h0F00, 1'b0);
                send(16'hABCD, 4'd8,  SRL, 16'h00AB, 1'b1);
                send(16'h8421, 4'd3,  SRA, 16'hF084, 1'b0);
                send(16'h8001, 4'd1,  ROL, 16'h0003, 1'b1);
                send(16'hFFFF, 4'd15, SLL, 16'h8000, 1'b1);
                send(16'h0000, 4'd7,  SRL, 16'h0000, 1'b0);
                send(16'hF00F, 4'd12, ROL, 16'hFF00, 1'b0);
                send(16'h7FFF, 4'd2,  SRA, 16'h1FFF, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream discards in-flight operands
        send(16'h1111, 4'd1, SLL, 16'h2222, 1'b0);
        send(16'h2222, 4'd1, SLL, 16'h4444, 1'b0);
        send(16'h3333, 4'd1, SLL, 16'h6666, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_carry", 32'(out_carry), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h00FF, 4'd8, SLL, 16'hFF00, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
